mult_result_bcd_reader: RTL and testbench

- Consumer of the multiplier's result/status register. It watches the held `done` flag and latches the signed 16-bit product.
- Converts the product to sign + magnitude, then to packed BCD using a sequential shift-add-3 (double-dabble) engine.
- Presents the digits, with a valid flag, to the 7-segment display driver.
- It is the read side of the result interface: `done` held high means "result available"; `valid` means "new operation, discard".

---
 rtl/mult_result_bcd_reader.sv | 83 ++++++++
 tb/tb_mult_result_bcd_reader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_bcd_reader.sv
// mult_result_bcd_reader: captures the signed product on a rising done and converts it to sign + packed BCD.
// A double-dabble engine processes one magnitude bit per clock; results publish after WIDTH clocks.
module mult_result_bcd_reader #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      resultado,
    input  logic                  done,
    input  logic                  valid,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  busy
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

    state_t           state;
    logic             done_q, sign_int, cap;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    acc, adj;
    logic [WIDTH-1:0] mag, mag_in;

    assign cap    = done & ~done_q;
    assign mag_in = resultado[WIDTH-1] ? -resultado : resultado;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            sign_int  <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mag       <= '0;
            sign      <= 1'b0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done_q <= done;
            if (valid) begin
                state     <= IDLE;
                sign      <= 1'b0;
                bcd       <= '0;
                bcd_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    CONVERT: begin
                        {acc, mag} <= {adj, mag} << 1;
                        cnt        <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            bcd       <= {adj[BW-2:0], mag[WIDTH-1]};
                            sign      <= sign_int;
                            bcd_valid <= 1'b1;
                            busy      <= 1'b0;
                            state     <= HOLD;
                        end
                    end
                    default: begin
                        if (cap) begin
                            mag       <= mag_in;
                            sign_int  <= resultado[WIDTH-1] & (|resultado);
                            acc       <= '0;
                            cnt       <= '0;
                            busy      <= 1'b1;
                            bcd_valid <= 1'b0;
                            state     <= CONVERT;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mult_result_bcd_reader.sv
// tb_mult_result_bcd_reader: table-driven conversion vectors plus directed abort, hold and reset sequences.
module tb_mult_result_bcd_reader;
    logic        clk = 1'b0;
    logic        rst, done, valid;
    logic [15:0] resultado;
    logic        sign, bcd_valid, busy;
    logic [19:0] bcd;
    int          checks = 0, fails = 0;

    typedef struct {
        logic [15:0] r;
        logic [19:0] bcd;
        logic        sign;
    } vec_t;
    vec_t vecs[10];

    mult_result_bcd_reader #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst), .resultado(resultado), .done(done), .valid(valid),
        .sign(sign), .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Counts clocks from just after the capture edge until busy falls.
    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic convert(input vec_t v);
        int n;
        resultado = v.r;
        done      = 1'b1;
        tick();
        chk("start_valid_low", bcd_valid, 0);
        wait_busy(n);
        chk("busy_cycles", n, 16);
        chk("bcd", bcd, v.bcd);
        chk("sign", sign, v.sign);
        chk("bcd_valid", bcd_valid, 1);
        done = 1'b0;
        tick();
    endtask

    initial begin
        int  n;
        logic bad;
        vecs[0] = '{16'h3039, 20'h12345, 1'b0};
        vecs[1] = '{16'hFFFF, 20'h00001, 1'b1};
        vecs[2] = '{16'h8000, 20'h32768, 1'b1};
        vecs[3] = '{16'h0000, 20'h00000, 1'b0};
        vecs[4] = '{16'h7FFF, 20'h32767, 1'b0};
        vecs[5] = '{16'h8001, 20'h32767, 1'b1};
        vecs[6] = '{16'h0064, 20'h00100, 1'b0};
        vecs[7] = '{16'hFF9C, 20'h00100, 1'b1};
        vecs[8] = '{16'h270F, 20'h09999, 1'b0};
        vecs[9] = '{16'h0007, 20'h00007, 1'b0};

        rst = 1'b1; done = 1'b0; valid = 1'b0; resultado = '0;
        #1;
        chk("rst_bcd", bcd, 0);
        chk("rst_sign", sign, 0);
        chk("rst_valid", bcd_valid, 0);
        chk("rst_busy", busy, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) convert(vecs[i]);

        // done held high: exactly one conversion
        resultado = 16'hC000;
        done      = 1'b1;
        tick();
        wait_busy(n);
        chk("hold_busy_cycles", n, 16);
        chk("hold_bcd", bcd, 20'h16384);
        chk("hold_sign", sign, 1);
        bad = 1'b0;
        repeat (50) begin
            tick();
            if (busy || !bcd_valid) bad = 1'b1;
        end
        chk("hold_no_reconvert", bad, 0);
        done = 1'b0;
        tick();

        // abort with valid at t+5
        resultado = 16'h0064;
        done      = 1'b1;
        tick();
        chk("conv_keeps_old_bcd", bcd, 20'h16384);
        repeat (4) tick();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("abort_valid", bcd_valid, 0);
        chk("abort_bcd", bcd, 0);
        chk("abort_sign", sign, 0);
        chk("abort_busy", busy, 0);
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (bcd_valid || busy) bad = 1'b1;
        end
        chk("abort_no_publish", bad, 0);
        done = 1'b0;
        tick();
        convert(vecs[6]);

        // new capture from HOLD: bcd holds old value until publish
        convert(vecs[9]);
        resultado = 16'hFF9C;
        done      = 1'b1;
        tick();
        chk("recap_valid_drop", bcd_valid, 0);
        chk("recap_bcd_held", bcd, 20'h00007);
        chk("recap_busy", busy, 1);
        wait_busy(n);
        chk("recap_cycles", n, 16);
        chk("recap_bcd", bcd, 20'h00100);
        chk("recap_sign", sign, 1);
        done = 1'b0;
        tick();

        // capture during CONVERT is ignored
        resultado = 16'h3039;
        done      = 1'b1;
        tick();
        repeat (4) tick();
        done = 1'b0;
        tick();
        done = 1'b1;
        tick();
        wait_busy(n);
        chk("ignore_cycles", n + 6, 16);
        chk("ignore_bcd", bcd, 20'h12345);
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (busy) bad = 1'b1;
        end
        chk("ignore_no_requeue", bad, 0);
        done = 1'b0;
        tick();

        // capture in the same cycle as valid is discarded
        resultado = 16'h0007;
        done      = 1'b1;
        valid     = 1'b1;
        tick();
        valid = 1'b0;
        chk("valid_cap_busy", busy, 0);
        tick();
        chk("valid_cap_later", busy, 0);
        done = 1'b0;
        tick();

        // reset mid-conversion
        resultado = 16'h3039;
        done      = 1'b1;
        tick();
        repeat (7) tick();
        done = 1'b0;
        rst  = 1'b1;
        #2;
        chk("midrst_busy", busy, 0);
        chk("midrst_bcd", bcd, 0);
        chk("midrst_sign", sign, 0);
        chk("midrst_valid", bcd_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        convert('{16'h1234, 20'h04660, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
